// File: rtl/keypad_tone_sequencer.sv
// keypad_tone_sequencer
//   Turns keypad presses into a square-wave tone for the bell pin.
//   mode=0 (live): the tone sounds only while the key is held.
//   mode=1 (queued): presses are buffered in a FIFO and played back one
//   after another. Each note plays for DUR_CYCLES cycles and is followed
//   by a gap of GAP_CYCLES silent cycles.
//   The half-period of a note is BASE_N + STEP_N*pos clk cycles.
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   key_pos/key_valid : keypad position code and key-held level
//   mode              : 0=live, 1=queued; any change flushes to IDLE
//   clr_ovf           : clears the sticky overflow flag
//   tone_out          : square-wave output
//   busy              : high whenever a note or a gap is in progress
//   cur_pos           : position of the current (or last) note
//   fifo_count        : number of queued notes
//   overflow          : sticky; set when a press is dropped on a full FIFO
module keypad_tone_sequencer #(
    parameter int KEY_W      = 4,
    parameter int N_W        = 12,
    parameter int BASE_N     = 1000,
    parameter int STEP_N     = 50,
    parameter int DEPTH      = 8,
    parameter int DUR_CYCLES = 25000000,
    parameter int GAP_CYCLES = 2500000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [KEY_W-1:0]             key_pos,
    input  logic                         key_valid,
    input  logic                         mode,
    input  logic                         clr_ovf,
    output logic                         tone_out,
    output logic                         busy,
    output logic [KEY_W-1:0]             cur_pos,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
    output logic                         overflow
);
    localparam int CW      = $clog2(DEPTH + 1);
    localparam int PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int DUR_MAX = (DUR_CYCLES > GAP_CYCLES) ? DUR_CYCLES : GAP_CYCLES;
    localparam int DW      = $clog2(DUR_MAX + 1);
    localparam longint MAX_N = longint'(BASE_N) + longint'(STEP_N) * ((longint'(1) << KEY_W) - 1);

    // Elaboration stops on parameter sets that cannot be built correctly.
    generate
        if (BASE_N < 1 || MAX_N >= (longint'(1) << N_W)) begin : g_bad_n
            $error("keypad_tone_sequencer: half-period range does not fit N_W");
        end
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("keypad_tone_sequencer: DEPTH must be a power of 2, >= 2");
        end
        if (DUR_CYCLES < 1 || GAP_CYCLES < 1) begin : g_bad_dur
            $error("keypad_tone_sequencer: DUR_CYCLES and GAP_CYCLES must be >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_PLAY_LIVE, S_PLAY_Q, S_GAP} state_t;

    state_t             state_q, state_d;
    logic               tone_q, tone_d;
    logic [N_W-1:0]     div_q, div_d;
    logic [DW-1:0]      dur_q, dur_d;
    logic [KEY_W-1:0]   cur_pos_q, cur_pos_d;
    logic [KEY_W-1:0]   fifo_q [DEPTH];
    logic [KEY_W-1:0]   fifo_d [DEPTH];
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               ovf_q, ovf_d;
    logic               key_q_q, mode_q_q;

    logic [N_W-1:0]     n_val;
    logic               rise, mode_chg, full, empty, div_wrap;
    logic               push, pop, drop;

    assign n_val    = N_W'(BASE_N) + N_W'(STEP_N) * N_W'(cur_pos_q);
    assign rise     = key_valid & ~key_q_q;
    assign mode_chg = mode ^ mode_q_q;
    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign div_wrap = (div_q == n_val - N_W'(1));

    always_comb begin
        state_d   = state_q;
        tone_d    = tone_q;
        div_d     = div_q;
        dur_d     = dur_q;
        cur_pos_d = cur_pos_q;
        fifo_d    = fifo_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
        push      = 1'b0;
        pop       = 1'b0;
        drop      = 1'b0;

        if (mode_chg) begin
            // A mode switch abandons whatever was playing and empties the queue.
            state_d  = S_IDLE;
            tone_d   = 1'b0;
            div_d    = '0;
            dur_d    = '0;
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!mode && rise) begin
                        cur_pos_d = key_pos;
                        state_d   = S_PLAY_LIVE;
                        div_d     = '0;
                        tone_d    = 1'b0;
                    end else if (mode && !empty) begin
                        pop = 1'b1;
                    end
                end
                S_PLAY_LIVE: begin
                    if (!key_valid) begin
                        state_d = S_IDLE;
                        tone_d  = 1'b0;
                        div_d   = '0;
                    end else begin
                        div_d  = div_wrap ? '0 : div_q + N_W'(1);
                        tone_d = div_wrap ? ~tone_q : tone_q;
                    end
                end
                S_PLAY_Q: begin
                    if (dur_q == DW'(DUR_CYCLES - 1)) begin
                        state_d = S_GAP;
                        dur_d   = '0;
                        tone_d  = 1'b0;
                        div_d   = '0;
                    end else begin
                        dur_d  = dur_q + DW'(1);
                        div_d  = div_wrap ? '0 : div_q + N_W'(1);
                        tone_d = div_wrap ? ~tone_q : tone_q;
                    end
                end
                default: begin // S_GAP
                    if (dur_q == DW'(GAP_CYCLES - 1)) begin
                        dur_d = '0;
                        if (!empty) pop = 1'b1;
                        else        state_d = S_IDLE;
                    end else begin
                        dur_d = dur_q + DW'(1);
                    end
                end
            endcase

            // A pop in the same cycle frees a slot, so a full FIFO still accepts.
            if (mode && rise) begin
                if (!full || pop) push = 1'b1;
                else              drop = 1'b1;
            end

            if (pop) begin
                cur_pos_d = fifo_q[rd_ptr_q];
                rd_ptr_d  = rd_ptr_q + PW'(1);
                state_d   = S_PLAY_Q;
                dur_d     = '0;
                div_d     = '0;
                tone_d    = 1'b0;
            end
            if (push) begin
                fifo_d[wr_ptr_q] = key_pos;
                wr_ptr_d         = wr_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end

        // Set beats clear when both happen in one cycle.
        if (drop)         ovf_d = 1'b1;
        else if (clr_ovf) ovf_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            tone_q    <= 1'b0;
            div_q     <= '0;
            dur_q     <= '0;
            cur_pos_q <= '0;
            for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            tone_q    <= tone_d;
            div_q     <= div_d;
            dur_q     <= dur_d;
            cur_pos_q <= cur_pos_d;
            fifo_q    <= fifo_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
        end
    end

    // The edge-detect and mode history keep sampling during reset. A key
    // that is held through reset therefore does not count as a fresh press,
    // and a mode level that is held through reset does not count as a change.
    always_ff @(posedge clk) begin
        key_q_q  <= key_valid;
        mode_q_q <= mode;
    end

    assign tone_out   = tone_q;
    assign busy       = (state_q != S_IDLE);
    assign cur_pos    = cur_pos_q;
    assign fifo_count = count_q;
    assign overflow   = ovf_q;
endmodule
